// File: rtl/can_msg_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : can_msg_fifo_pkg
// Brief   : Shared constants for the Basic CAN message buffer: frame size,
//           byte width, byte index map and the storage reset fill pattern.
// Revision: 1.0 - initial release
// ============================================================================
package can_msg_fifo_pkg;

  // Frame geometry: frame info + 2 ID bytes + 8 data bytes + 2 spare
  localparam int CAN_FRAME_BYTES = 13;
  localparam int CAN_DW          = 8;

  // Byte index map inside one message slot
  localparam int FRAME_INFO = 0;
  localparam int ID1        = 1;
  localparam int ID2        = 2;
  localparam int DATA0      = 3;

  // Value every storage byte takes on reset
  localparam logic [CAN_DW-1:0] CAN_FILL_BYTE = '1;

endpackage : can_msg_fifo_pkg
`default_nettype wire

// File: rtl/can_msg_slot.sv
`default_nettype none
// ============================================================================
// Module  : can_msg_slot
// Brief   : One message slot: BYTES x DW register array with a byte write
//           enable, reset to all ones, and a combinational byte read mux.
//           Addresses at or beyond the last byte alias onto the last byte.
// Revision: 1.0 - initial release
// ============================================================================
module can_msg_slot
  import can_msg_fifo_pkg::*;
#(
  parameter int DW    = CAN_DW,
  parameter int BYTES = CAN_FRAME_BYTES,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rdata_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(BYTES - 1);

  logic [DW-1:0] mem_q [BYTES];
  logic [AW-1:0] wr_sel;
  logic [AW-1:0] rd_sel;

  // Clamp out-of-range byte indices onto the last byte of the slot
  assign wr_sel = (wr_addr_i >= LAST_IDX) ? LAST_IDX : wr_addr_i;
  assign rd_sel = (rd_addr_i >= LAST_IDX) ? LAST_IDX : rd_addr_i;

  // Byte storage: fill with ones on reset, single-byte write otherwise
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int b = 0; b < BYTES; b++) begin
        mem_q[b] <= '1;
      end
    end else if (we_i) begin
      mem_q[wr_sel] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_sel];

endmodule : can_msg_slot
`default_nettype wire

// File: rtl/can_msg_fifo.sv
`default_nettype none
// ============================================================================
// Module  : can_msg_fifo
// Brief   : Multi-slot CAN message buffer. Producer byte-writes the tail slot
//           and commits it; consumer reads the head slot combinationally and
//           releases it. Sticky overrun flags a commit dropped while full.
// Revision: 1.0 - initial release
// ============================================================================
module can_msg_fifo
  import can_msg_fifo_pkg::*;
#(
  parameter int DW    = CAN_DW,
  parameter int BYTES = CAN_FRAME_BYTES,
  parameter int SLOTS = 4,
  parameter int AW    = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          we_b,
  input  logic [DW-1:0] datain,
  input  logic [AW-1:0] wr_adress,
  input  logic          wr_commit,
  input  logic [AW-1:0] rd_adress,
  input  logic          rd_release,
  input  logic          clr_overrun,
  output logic [DW-1:0] dataout,
  output logic [CW-1:0] msg_count,
  output logic          empty,
  output logic          full,
  output logic          overrun
);

  localparam int              PW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(SLOTS);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overrun_q, overrun_d;

  logic          full_w;
  logic          empty_w;
  logic          do_commit;
  logic          do_release;
  logic          ovr_event;
  logic          wr_en_w;
  logic [DW-1:0] slot_rdata [SLOTS];

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);

  // Both operations are judged on the pre-edge count. A commit while full is
  // only accepted if a release frees the head slot in the same cycle.
  assign do_commit  = wr_commit && (!full_w || rd_release);
  assign do_release = rd_release && !empty_w;
  assign ovr_event  = wr_commit && full_w && !rd_release;

  // Writes while full would land in the head slot (tail aliases head)
  assign wr_en_w = !we_b && !full_w;

  // Next-state for pointers, message count and sticky overrun (set wins)
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(do_commit) - CW'(do_release);
    overrun_d = overrun_q;
    if (do_commit)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_release) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (clr_overrun) overrun_d = 1'b0;
    if (ovr_event)   overrun_d = 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    can_msg_slot #(
      .DW    (DW),
      .BYTES (BYTES),
      .AW    (AW)
    ) u_slot (
      .clk       (clk),
      .rst_b     (rst_b),
      .we_i      (wr_en_w && (wr_ptr_q == PW'(g))),
      .wr_addr_i (wr_adress),
      .wdata_i   (datain),
      .rd_addr_i (rd_adress),
      .rdata_o   (slot_rdata[g])
    );
  end

  assign dataout   = slot_rdata[rd_ptr_q];
  assign msg_count = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overrun   = overrun_q;

endmodule : can_msg_fifo
`default_nettype wire

// File: tb/tb_can_msg_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_can_msg_fifo
// Brief   : Self-checking bench for can_msg_fifo. Stimulus pushes expected
//           values into a scoreboard queue; a monitor on the falling clock
//           edge pops and compares them against the DUT outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_can_msg_fifo;
  import can_msg_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int BYTES = 13;
  localparam int SLOTS = 4;
  localparam int AW    = 4;
  localparam int CW    = 3;

  localparam int K_DATA  = 0;
  localparam int K_COUNT = 1;
  localparam int K_EMPTY = 2;
  localparam int K_FULL  = 3;
  localparam int K_OVR   = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          we_b;
  logic [DW-1:0] datain;
  logic [AW-1:0] wr_adress;
  logic          wr_commit;
  logic [AW-1:0] rd_adress;
  logic          rd_release;
  logic          clr_overrun;
  logic [DW-1:0] dataout;
  logic [CW-1:0] msg_count;
  logic          empty;
  logic          full;
  logic          overrun;

  always #5 clk = ~clk;

  can_msg_fifo #(
    .DW(DW), .BYTES(BYTES), .SLOTS(SLOTS), .AW(AW), .CW(CW)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .we_b        (we_b),
    .datain      (datain),
    .wr_adress   (wr_adress),
    .wr_commit   (wr_commit),
    .rd_adress   (rd_adress),
    .rd_release  (rd_release),
    .clr_overrun (clr_overrun),
    .dataout     (dataout),
    .msg_count   (msg_count),
    .empty       (empty),
    .full        (full),
    .overrun     (overrun)
  );

  typedef struct {
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_DATA:  act = dataout;
        K_COUNT: act = 8'(msg_count);
        K_EMPTY: act = {7'b0, empty};
        K_FULL:  act = {7'b0, full};
        default: act = {7'b0, overrun};
      endcase
      n_total++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
    end
  end

  task automatic push(input int k, input logic [7:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we_b        = 1'b1;
    wr_commit   = 1'b0;
    rd_release  = 1'b0;
    clr_overrun = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we_b      = 1'b0;
    wr_adress = a;
    datain    = d;
    step();
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    step();
  endtask

  task automatic pop_head();
    rd_release = 1'b1;
    step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] v, input string n);
    rd_adress = a;
    push(K_DATA, v, n);
    settle();
  endtask

  task automatic st(input int c, input bit e, input bit f, input bit o, input string n);
    push(K_COUNT, 8'(c), {n, ".count"});
    push(K_EMPTY, {7'b0, e}, {n, ".empty"});
    push(K_FULL,  {7'b0, f}, {n, ".full"});
    push(K_OVR,   {7'b0, o}, {n, ".overrun"});
    settle();
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_b     = 1'b0;
    idle();
    datain    = '0;
    wr_adress = '0;
    rd_adress = '0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    // Reset state
    st(0, 1, 0, 0, "reset");
    rd(4'(FRAME_INFO), CAN_FILL_BYTE, "reset_data");

    // Asynchronous reset asserted in the middle of a write
    for (int i = 0; i < 3; i++) wr(4'(i), 8'h55);
    commit();
    st(1, 0, 0, 0, "pre_rst");
    rd(4'(0), 8'h55, "pre_rst_data");
    we_b      = 1'b0;
    wr_adress = 4'd3;
    datain    = 8'h99;
    rst_b     = 1'b0;
    push(K_DATA, 8'hFF, "async_rst.data");
    st(0, 1, 0, 0, "async_rst");
    rst_b = 1'b1;
    idle();
    rd(4'd3, 8'hFF, "rst_write_dropped");

    // Single frame, including address clamping on read
    for (int i = 0; i < BYTES; i++) wr(4'(i), 8'(8'h10 + i));
    commit();
    st(1, 0, 0, 0, "single");
    rd(4'd5,  8'h15, "single_adr5");
    rd(4'd15, 8'h1C, "single_adr15");
    rd(4'(FRAME_INFO), 8'h10, "single_adr0");
    pop_head();
    st(0, 1, 0, 0, "single_rel");

    // Fill all slots, then overrun and a write while full
    for (int k = 0; k < SLOTS; k++) begin
      wr(4'(FRAME_INFO), 8'(8'hA0 + k));
      wr(4'(DATA0), 8'(k));
      commit();
    end
    st(4, 0, 1, 0, "fill");
    wr(4'(FRAME_INFO), 8'hEE);
    commit();
    st(4, 0, 1, 1, "overrun");
    rd(4'(FRAME_INFO), 8'hA0, "full_write_ignored");
    for (int k = 0; k < SLOTS; k++) begin
      rd(4'(FRAME_INFO), 8'(8'hA0 + k), "fill_tag");
      rd(4'(DATA0), 8'(k), "fill_data0");
      pop_head();
    end
    st(0, 1, 0, 1, "drained");
    clr_overrun = 1'b1;
    step();
    st(0, 1, 0, 0, "clr");

    // Full with simultaneous commit and release
    for (int k = 0; k < SLOTS; k++) begin
      wr(4'(FRAME_INFO), 8'(8'hB0 + k));
      commit();
    end
    st(4, 0, 1, 0, "refill");
    wr_commit  = 1'b1;
    rd_release = 1'b1;
    step();
    st(4, 0, 1, 0, "full_cr");
    rd(4'(FRAME_INFO), 8'hB1, "full_cr_b1");
    pop_head();
    rd(4'(FRAME_INFO), 8'hB2, "full_cr_b2");
    pop_head();
    rd(4'(FRAME_INFO), 8'hB3, "full_cr_b3");
    pop_head();
    rd(4'(FRAME_INFO), 8'hB0, "full_cr_aliased");
    pop_head();
    st(0, 1, 0, 0, "full_cr_drain");

    // Empty with simultaneous commit and release; release on empty
    wr(4'(FRAME_INFO), 8'hC5);
    wr_commit  = 1'b1;
    rd_release = 1'b1;
    step();
    st(1, 0, 0, 0, "empty_cr");
    rd(4'(FRAME_INFO), 8'hC5, "empty_cr_head");
    pop_head();
    st(0, 1, 0, 0, "empty_cr_rel");
    pop_head();
    st(0, 1, 0, 0, "rel_on_empty");
    wr(4'(FRAME_INFO), 8'hD7);
    commit();
    rd(4'(FRAME_INFO), 8'hD7, "no_ptr_move");
    pop_head();
    st(0, 1, 0, 0, "no_ptr_move_rel");

    // Pointer wrap with per-frame data integrity; high address clamps
    for (int i = 0; i < 10; i++) begin
      wr(4'(FRAME_INFO), 8'(8'h30 + i));
      wr(4'd15, 8'(8'h60 + i));
      commit();
      push(K_COUNT, 8'd1, "wrap.count");
      rd(4'(FRAME_INFO), 8'(8'h30 + i), "wrap_tag");
      rd(4'd12, 8'(8'h60 + i), "wrap_last");
      pop_head();
    end
    st(0, 1, 0, 0, "wrap_end");

    // Clear and new overrun in the same cycle: set wins
    for (int k = 0; k < SLOTS; k++) begin
      wr(4'(ID1), 8'(8'h40 + k));
      commit();
    end
    wr_commit   = 1'b1;
    clr_overrun = 1'b1;
    step();
    st(4, 0, 1, 1, "set_wins");
    clr_overrun = 1'b1;
    step();
    st(4, 0, 1, 0, "clr_after");
    rd(4'(ID1), 8'h40, "set_wins_head");
    rd(4'(ID2), CAN_FILL_BYTE, "unwritten_byte");

    settle();
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_can_msg_fifo
`default_nettype wire
